// File: rtl/cpu_trap_ctrl_if.sv
// Commit-side and fetch-side signals of the trap controller.
// master = pipeline/CSR/fetch side, slave = cpu_trap_ctrl.
interface cpu_trap_ctrl_if;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_val;
  logic        sret_req;
  logic        has_intr;
  logic [4:0]  intr_index;
  logic [31:0] handler_addr;
  logic [31:0] continue_addr;
  logic        redirect_ready;
  logic        exception;
  logic        exc_leave;
  logic [31:0] exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_value;
  logic        flush;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] trap_cnt;

  modport master (
    output inst_valid, inst_pc, exc_req, exc_code, exc_val, sret_req, has_intr,
           intr_index, handler_addr, continue_addr, redirect_ready,
    input  exception, exc_leave, exc_cause, exc_pc, exc_value, flush, stall,
           redirect_valid, redirect_pc, trap_cnt
  );

  modport slave (
    input  inst_valid, inst_pc, exc_req, exc_code, exc_val, sret_req, has_intr,
           intr_index, handler_addr, continue_addr, redirect_ready,
    output exception, exc_leave, exc_cause, exc_pc, exc_value, flush, stall,
           redirect_valid, redirect_pc, trap_cnt
  );
endinterface

// File: rtl/cpu_trap_ctrl.sv
// Trap entry/return sequencer: latches cause/epc/tval, pulses CSR strobes, flushes and redirects fetch.
// Optional vectored interrupt targets: define CPU_TRAP_VECTORED_EN.
module cpu_trap_ctrl (
  input  logic           clk,
  input  logic           rst,
  cpu_trap_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ENTER, LEAVE, REDIRECT} state_e;

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] tval_q, tval_d;
  logic [31:0] rpc_q, rpc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] base, target;
  logic        exception, exc_leave, flush, redirect_valid;

  assign base = {bus.handler_addr[31:2], 2'b00};

  // Interrupt index is taken from the latched cause, so the target is stable in ENTER.
`ifdef CPU_TRAP_VECTORED_EN
  assign target = (cause_q[31] && bus.handler_addr[1:0] == 2'b01)
                ? base + {25'b0, cause_q[4:0], 2'b00} : base;
`else
  assign target = base;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cause_q <= '0;
      epc_q   <= '0;
      tval_q  <= '0;
      rpc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
      rpc_q   <= rpc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    epc_d          = epc_q;
    tval_d         = tval_q;
    rpc_d          = rpc_q;
    cnt_d          = cnt_q;
    exception      = 1'b0;
    exc_leave      = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.inst_valid) begin
          if (bus.exc_req) begin
            cause_d = {27'b0, bus.exc_code};
            epc_d   = bus.inst_pc;
            tval_d  = bus.exc_val;
            state_d = ENTER;
          end else if (bus.has_intr) begin
            cause_d = {1'b1, 26'b0, bus.intr_index};
            epc_d   = bus.inst_pc;
            tval_d  = '0;
            state_d = ENTER;
          end else if (bus.sret_req) begin
            state_d = LEAVE;
          end
        end
      end
      ENTER: begin
        exception = 1'b1;
        flush     = 1'b1;
        rpc_d     = target;
        cnt_d     = cnt_q + 16'd1;
        state_d   = REDIRECT;
      end
      LEAVE: begin
        exc_leave = 1'b1;
        flush     = 1'b1;
        rpc_d     = bus.continue_addr;
        state_d   = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        if (bus.redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.exception      = exception;
  assign bus.exc_leave      = exc_leave;
  assign bus.flush          = flush;
  assign bus.stall          = (state_q != IDLE);
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = rpc_q;
  assign bus.exc_cause      = cause_q;
  assign bus.exc_pc         = epc_q;
  assign bus.exc_value      = tval_q;
  assign bus.trap_cnt       = cnt_q;
endmodule
